// File: rtl/bf_alu_sched.sv
// Run-length sequencer and round-robin arbiter for the shared inc/dec ALU.
// Two requesters (cell path, pointer path) each submit an operand plus a step
// count; the block loops the ALU result back for that many steps and returns
// the final value tagged with the requester ID.

package bf_alu_pkg;
  localparam int unsigned ALU_OP_W = 2;
  localparam logic [ALU_OP_W-1:0] ALU_INC = 2'd0;
  localparam logic [ALU_OP_W-1:0] ALU_DEC = 2'd1;
endpackage

module bf_alu_sched
  import bf_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [ALU_OP_W-1:0] req0_op_i,
  input  logic [WIDTH-1:0]    req0_data_i,
  input  logic [CNT_W-1:0]    req0_count_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [ALU_OP_W-1:0] req1_op_i,
  input  logic [WIDTH-1:0]    req1_data_i,
  input  logic [CNT_W-1:0]    req1_count_i,
  output logic [WIDTH-1:0]    alu_data_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  input  logic [WIDTH-1:0]    alu_result_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_id_o,
  output logic [WIDTH-1:0]    rsp_data_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [ALU_OP_W-1:0]   op_q, op_d;
  logic                  id_q, id_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant0, grant1;

  // State and datapath registers; last_grant resets to 1 so req0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      remaining_q  <= '0;
      op_q         <= ALU_INC;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      remaining_q  <= remaining_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbitration, step sequencing and response handshake
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    remaining_d  = remaining_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is suppressed while reset is held so no grant is advertised then
        grant0 = !reset && req0_valid_i && (!req1_valid_i || last_grant_q);
        grant1 = !reset && req1_valid_i && (!req0_valid_i || !last_grant_q);
        if (grant0) begin
          acc_d        = req0_data_i;
          op_d         = req0_op_i;
          remaining_d  = req0_count_i;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = (req0_count_i != '0) ? RUN : DONE;
        end else if (grant1) begin
          acc_d        = req1_data_i;
          op_d         = req1_op_i;
          remaining_d  = req1_count_i;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = (req1_count_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        acc_d       = alu_result_i;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign alu_data_o   = acc_q;
  assign alu_op_o     = op_q;
  assign rsp_data_o   = acc_q;
  assign rsp_id_o     = id_q;
  assign rsp_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_bf_alu_sched.sv
// Directed bench for bf_alu_sched with a behavioural inc/dec ALU on the loop.
module tb_bf_alu_sched;
  import bf_alu_pkg::*;

  logic       clk;
  logic       reset;
  logic       req0_valid, req0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_data;
  logic [3:0] req0_count;
  logic       req1_valid, req1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_data;
  logic [3:0] req1_count;
  logic [7:0] alu_data, alu_result;
  logic [1:0] alu_op;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_data;

  int total = 0;
  int bad   = 0;

  bf_alu_sched #(.WIDTH(8), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_op_i    (req0_op),
    .req0_data_i  (req0_data),
    .req0_count_i (req0_count),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_op_i    (req1_op),
    .req1_data_i  (req1_data),
    .req1_count_i (req1_count),
    .alu_data_o   (alu_data),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data),
    .busy_o       (busy)
  );

  // External combinational ALU: DEC subtracts one, every other op increments
  assign alu_result = (alu_op == ALU_DEC) ? alu_data - 8'd1 : alu_data + 8'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request, wait for its grant and for rsp_valid; lat counts negedges after the grant edge
  task automatic run_txn(input logic id, input logic [1:0] op, input logic [7:0] data,
                         input logic [3:0] cnt, output logic [7:0] rdata,
                         output logic rid, output int lat);
    logic got;
    logic seen;
    got = 1'b0; seen = 1'b0; lat = -1; rdata = 8'h00; rid = 1'b0;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_data = data; req0_count = cnt;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_data = data; req1_count = cnt;
    end
    #1;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    @(posedge clk); #1;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (got) begin
      for (int n = 1; n <= 40 && !seen; n++) begin
        @(negedge clk); #1;
        if (rsp_valid) begin
          seen = 1'b1; lat = n; rdata = rsp_data; rid = rsp_id;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_INC; req0_data = 8'h55; req0_count = 4'd2;
    @(negedge clk); #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready); end
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_valid_busy: got v=%b b=%b want 0 0", rsp_valid, busy); end
    total++; if (rsp_data !== 8'h00 || alu_data !== 8'h00 || alu_op !== ALU_INC) begin
      bad++; $display("FAIL reset_data: got rsp=%h alu=%h op=%h want 00 00 0", rsp_data, alu_data, alu_op); end
    req0_valid = 1'b0;
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b r0=%b want 0 0", busy, req0_ready); end
  endtask

  task automatic test_basic;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ALU_INC; req0_data = 8'h05; req0_count = 4'd3;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL basic_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++; if (alu_data !== 8'h05 + 8'(k) || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL basic_run%0d: got alu=%h v=%b r0=%b busy=%b want %h 0 0 1",
                        k, alu_data, rsp_valid, req0_ready, busy, 8'h05 + 8'(k)); end
    end
    req0_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h08 || rsp_id !== 1'b0) begin
      bad++; $display("FAIL basic_rsp: got v=%b data=%h id=%b want 1 08 0", rsp_valid, rsp_data, rsp_id); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle: got v=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_wrap;
    logic [7:0] d; logic id; int lat;
    rsp_ready = 1'b1;
    run_txn(1'b1, ALU_DEC, 8'h01, 4'd2, d, id, lat);
    total++; if (d !== 8'hFF || id !== 1'b1 || lat != 3) begin
      bad++; $display("FAIL wrap_dec: got data=%h id=%b lat=%0d want ff 1 3", d, id, lat); end
    run_txn(1'b1, ALU_INC, 8'hFE, 4'd3, d, id, lat);
    total++; if (d !== 8'h01 || id !== 1'b1 || lat != 4) begin
      bad++; $display("FAIL wrap_inc: got data=%h id=%b lat=%0d want 01 1 4", d, id, lat); end
    run_txn(1'b0, ALU_INC, 8'hF0, 4'd15, d, id, lat);
    total++; if (d !== 8'hFF || id !== 1'b0 || lat != 16) begin
      bad++; $display("FAIL max_count: got data=%h id=%b lat=%0d want ff 0 16", d, id, lat); end
  endtask

  task automatic test_zero_count;
    logic [7:0] d; logic id; int lat;
    rsp_ready = 1'b1;
    run_txn(1'b0, ALU_INC, 8'h3C, 4'd0, d, id, lat);
    total++; if (d !== 8'h3C || id !== 1'b0 || lat != 1) begin
      bad++; $display("FAIL zero_count: got data=%h id=%b lat=%0d want 3c 0 1", d, id, lat); end
  endtask

  task automatic test_other_op;
    logic [7:0] d; logic id; int lat;
    rsp_ready = 1'b1;
    run_txn(1'b0, 2'd2, 8'h40, 4'd2, d, id, lat);
    total++; if (d !== 8'h42 || alu_op !== 2'd2 || lat != 3) begin
      bad++; $display("FAIL other_op: got data=%h op=%h lat=%0d want 42 2 3", d, alu_op, lat); end
  endtask

  task automatic test_contention;
    int both, viol, ng, nr, idle_wait;
    logic       g  [4];
    logic [7:0] rd [4];
    logic       ri [4];
    both = 0; viol = 0; ng = 0; nr = 0; idle_wait = 0;
    rsp_ready = 1'b1;
    @(negedge clk); reset = 1'b1;
    req0_valid = 1'b1; req0_op = ALU_INC; req0_data = 8'h10; req0_count = 4'd1;
    req1_valid = 1'b1; req1_op = ALU_DEC; req1_data = 8'h20; req1_count = 4'd1;
    @(negedge clk); #2 reset = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (req0_ready && req1_ready) both++;
      if (rsp_valid && (req0_ready || req1_ready)) viol++;
      if ((req0_ready || req1_ready) && ng < 4) begin g[ng] = req1_ready; ng++; end
      if (rsp_valid && nr < 4) begin rd[nr] = rsp_data; ri[nr] = rsp_id; nr++; end
      @(negedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (both != 0 || viol != 0) begin
      bad++; $display("FAIL cont_ready_excl: got both=%0d ready_in_done=%0d want 0 0", both, viol); end
    total++; if (ng != 4 || nr != 4) begin
      bad++; $display("FAIL cont_counts: got grants=%0d rsps=%0d want 4 4", ng, nr); end
    for (int i = 0; i < 4; i++) begin
      if (i < ng && i < nr) begin
        total++; if (g[i] !== 1'(i % 2) || ri[i] !== 1'(i % 2) || rd[i] !== ((i % 2 == 1) ? 8'h1F : 8'h11)) begin
          bad++; $display("FAIL cont_seq%0d: got grant=%b id=%b data=%h want %0d %0d %h",
                          i, g[i], ri[i], rd[i], i % 2, i % 2, (i % 2 == 1) ? 8'h1F : 8'h11); end
      end
    end
    while (busy && idle_wait < 20) begin @(negedge clk); #1; idle_wait++; end
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL cont_drain: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure;
    logic [7:0] d; logic id; int lat;
    rsp_ready = 1'b0;
    run_txn(1'b0, ALU_DEC, 8'h80, 4'd2, d, id, lat);
    total++; if (d !== 8'h7E || id !== 1'b0 || lat != 3) begin
      bad++; $display("FAIL bp_rsp: got data=%h id=%b lat=%0d want 7e 0 3", d, id, lat); end
    req1_valid = 1'b1; req1_op = ALU_INC; req1_data = 8'hA0; req1_count = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h7E || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b data=%h busy=%b r0=%b r1=%b want 1 7e 1 0 0",
                        k, rsp_valid, rsp_data, busy, req0_ready, req1_ready); end
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b0) begin
      bad++; $display("FAIL bp_no_grant_in_handshake: got r1=%b want 0", req1_ready); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: got v=%b busy=%b r1=%b want 0 0 1", rsp_valid, busy, req1_ready); end
    req1_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_idle: got busy=%b v=%b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_async_reset;
    logic [7:0] d; logic id; int lat; int spurious;
    spurious = 0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ALU_INC; req0_data = 8'h00; req0_count = 4'd10;
    #1;
    total++; if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL ar_grant: got r0=%b want 1", req0_ready); end
    @(posedge clk); #1 req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); #1; end
    total++; if (busy !== 1'b1 || alu_data !== 8'h02) begin
      bad++; $display("FAIL ar_running: got busy=%b alu=%h want 1 02", busy, alu_data); end
    #1 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_data !== 8'h00 || rsp_data !== 8'h00 || alu_op !== ALU_INC || rsp_id !== 1'b0) begin
      bad++; $display("FAIL ar_immediate: got busy=%b v=%b alu=%h rsp=%h op=%h id=%b want 0 0 00 00 0 0",
                      busy, rsp_valid, alu_data, rsp_data, alu_op, rsp_id); end
    @(posedge clk); @(negedge clk); #2 reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      if (rsp_valid || busy) spurious++;
    end
    total++; if (spurious != 0) begin
      bad++; $display("FAIL ar_no_rsp: got %0d active cycles want 0", spurious); end
    run_txn(1'b1, ALU_DEC, 8'h05, 4'd4, d, id, lat);
    total++; if (d !== 8'h01 || id !== 1'b1 || lat != 5) begin
      bad++; $display("FAIL ar_fresh: got data=%h id=%b lat=%0d want 01 1 5", d, id, lat); end
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = ALU_INC; req0_data = 8'h00; req0_count = 4'd0;
    req1_valid = 1'b0; req1_op = ALU_INC; req1_data = 8'h00; req1_count = 4'd0;
    test_reset;
    test_basic;
    test_wrap;
    test_zero_count;
    test_other_op;
    test_contention;
    test_backpressure;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
